fir_xifu_ex_simd: RTL and testbench

//  Parametrised execute stage of the FIR XIFU coprocessor: SIMD signed dot-product (wrapping or saturating)

---
 rtl/fir_xifu_ex_simd.sv | 156 +++++++++++++++
 tb/tb_fir_xifu_ex_simd.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_ex_simd.sv
// fir_xifu_ex_simd: FIR XIFU execute stage - SIMD signed dot product (wrap/saturate) and post-increment
// load/store issue, one instruction in flight between ID and WB.
module fir_xifu_ex_simd #(
   parameter int XLEN     = 32,
   parameter int ELEM_W   = 16,
   parameter int MUL_PIPE = 0,
   parameter int ID_W     = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      in_instr_i,
   input  logic [ID_W-1:0] in_id_i,
   input  logic [4:0]      in_rd_i,
   input  logic [XLEN-1:0] in_op_a_i,
   input  logic [XLEN-1:0] in_op_b_i,
   input  logic [XLEN-1:0] in_op_c_i,
   input  logic [11:0]     in_offset_i,
   input  logic            commit_valid_i,
   input  logic [ID_W-1:0] commit_id_i,
   input  logic            commit_kill_i,
   output logic            mem_valid_o,
   input  logic            mem_ready_i,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [ID_W-1:0] mem_id_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_result_o,
   output logic [4:0]      out_rd_o,
   output logic [ID_W-1:0] out_id_o,
   output logic [2:0]      out_instr_o
);
   localparam int LANES = XLEN / ELEM_W;
   localparam int PW = 2 * ELEM_W;
   localparam logic [2:0] I_LW = 3'd1, I_SW = 3'd2, I_DOTP = 3'd3, I_DOTPS = 3'd4;
   localparam logic signed [XLEN+1:0] S_MAX = {3'b000, {(XLEN-1){1'b1}}};
   localparam logic signed [XLEN+1:0] S_MIN = {3'b111, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MEM, MUL, DONE} state_e;

   state_e state_q, state_d, acc_state;
   logic [2:0] instr_q, instr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [4:0] rd_q, rd_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, c_q, c_d, res_q, res_d, next_addr;
   logic [LANES-1:0][PW-1:0] prod_q, prod_d, prod_in;
   logic committed_q, committed_d;
   logic accept, cmt_hit, kill_hit, in_mem, in_dot;

   // Accumulate at XLEN+2 bits so the saturating clamp sees the true sum.
   function automatic logic [XLEN-1:0] reduce(input logic [LANES-1:0][PW-1:0] p,
                                              input logic [XLEN-1:0] c, input logic sat);
      logic signed [XLEN+1:0] s;
      s = {{2{c[XLEN-1]}}, c};
      for (int i = 0; i < LANES; i++) s += {{(XLEN+2-PW){p[i][PW-1]}}, p[i]};
      return (sat && s > S_MAX) ? S_MAX[XLEN-1:0] : (sat && s < S_MIN) ? S_MIN[XLEN-1:0] : s[XLEN-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < LANES; i++)
         prod_in[i] = PW'($signed(in_op_a_i[i*ELEM_W +: ELEM_W])) * PW'($signed(in_op_b_i[i*ELEM_W +: ELEM_W]));
   end

   assign next_addr   = in_op_a_i + {{(XLEN-12){in_offset_i[11]}}, in_offset_i};
   assign in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign cmt_hit     = commit_valid_i & ~commit_kill_i & (commit_id_i == id_q);
   assign kill_hit    = commit_valid_i & commit_kill_i & (commit_id_i == id_q);
   assign in_mem      = (in_instr_i == I_LW) | (in_instr_i == I_SW);
   assign in_dot      = (in_instr_i == I_DOTP) | (in_instr_i == I_DOTPS);
   assign acc_state   = in_mem ? MEM : in_dot ? ((MUL_PIPE != 0) ? MUL : DONE) : IDLE;
   // Stores wait for commit; a commit arriving this very cycle releases them immediately.
   assign mem_valid_o = (state_q == MEM) & ((instr_q == I_LW) | committed_q | cmt_hit);
   assign mem_we_o     = instr_q == I_SW;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign mem_id_o     = id_q;
   assign out_valid_o  = state_q == DONE;
   assign out_result_o = res_q;
   assign out_rd_o     = rd_q;
   assign out_id_o     = id_q;
   assign out_instr_o  = instr_q;

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      id_d        = id_q;
      rd_d        = rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      c_d         = c_q;
      res_d       = res_q;
      prod_d      = prod_q;
      committed_d = committed_q | cmt_hit;
      if (clear_i) begin
         state_d     = IDLE;
         instr_d     = '0;
         id_d        = '0;
         rd_d        = '0;
         addr_d      = '0;
         wdata_d     = '0;
         c_d         = '0;
         res_d       = '0;
         prod_d      = '0;
         committed_d = 1'b0;
      end else if (accept) begin
         state_d     = acc_state;
         instr_d     = in_instr_i;
         id_d        = in_id_i;
         rd_d        = in_rd_i;
         addr_d      = in_op_a_i;
         wdata_d     = in_op_b_i;
         c_d         = in_op_c_i;
         prod_d      = prod_in;
         res_d       = in_mem ? next_addr : (MUL_PIPE != 0) ? res_q : reduce(prod_in, in_op_c_i, in_instr_i == I_DOTPS);
         committed_d = commit_valid_i & ~commit_kill_i & (commit_id_i == in_id_i);
      end else if (state_q == MEM) begin
         state_d = (mem_valid_o & mem_ready_i) ? DONE : kill_hit ? IDLE : MEM;
      end else if (state_q == MUL) begin
         state_d = kill_hit ? IDLE : DONE;
         res_d   = reduce(prod_q, c_q, instr_q == I_DOTPS);
      end else if (state_q == DONE && out_ready_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         instr_q     <= '0;
         id_q        <= '0;
         rd_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         c_q         <= '0;
         res_q       <= '0;
         prod_q      <= '0;
         committed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         id_q        <= id_d;
         rd_q        <= rd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         c_q         <= c_d;
         res_q       <= res_d;
         prod_q      <= prod_d;
         committed_q <= committed_d;
      end
   end
endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// tb_fir_xifu_ex_simd: table-driven dot-product vectors plus hand sequences for memory, kill, stall and clear;
// results are checked through a scoreboard queue on the WB handshake.
module tb_fir_xifu_ex_simd;
   logic clk = 0, rst_n = 0, clear = 0;
   always #5 clk = ~clk;

   logic        in_valid = 0, in_ready, commit_valid = 0, commit_kill = 0, mem_ready = 0, out_ready = 1;
   logic [2:0]  in_instr = 0, out_instr;
   logic [3:0]  in_id = 0, commit_id = 0, mem_id, out_id;
   logic [4:0]  in_rd = 0, out_rd;
   logic [31:0] op_a = 0, op_b = 0, op_c = 0, mem_addr, mem_wdata, out_result;
   logic [11:0] offset = 0;
   logic        mem_valid, mem_we, out_valid;

   logic        e_valid = 0, e_ready, e_cv = 0, e_ck = 0, e_mvalid, e_mwe, e_ovalid;
   logic [2:0]  e_instr = 0, e_oinstr;
   logic [3:0]  e_id = 0, e_cid = 0, e_mid, e_oid;
   logic [4:0]  e_ord;
   logic [31:0] e_a = 0, e_b = 0, e_c = 0, e_maddr, e_mwdata, e_res;

   fir_xifu_ex_simd dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_instr_i(in_instr), .in_id_i(in_id), .in_rd_i(in_rd), .in_op_a_i(op_a), .in_op_b_i(op_b),
      .in_op_c_i(op_c), .in_offset_i(offset), .commit_valid_i(commit_valid), .commit_id_i(commit_id),
      .commit_kill_i(commit_kill), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_id_o(mem_id), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_result_o(out_result), .out_rd_o(out_rd), .out_id_o(out_id),
      .out_instr_o(out_instr));

   fir_xifu_ex_simd #(.ELEM_W(8), .MUL_PIPE(1)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .in_valid_i(e_valid), .in_ready_o(e_ready),
      .in_instr_i(e_instr), .in_id_i(e_id), .in_rd_i(5'd0), .in_op_a_i(e_a), .in_op_b_i(e_b),
      .in_op_c_i(e_c), .in_offset_i(12'd0), .commit_valid_i(e_cv), .commit_id_i(e_cid),
      .commit_kill_i(e_ck), .mem_valid_o(e_mvalid), .mem_ready_i(1'b0), .mem_we_o(e_mwe),
      .mem_addr_o(e_maddr), .mem_wdata_o(e_mwdata), .mem_id_o(e_mid), .out_valid_o(e_ovalid),
      .out_ready_i(1'b1), .out_result_o(e_res), .out_rd_o(e_ord), .out_id_o(e_oid),
      .out_instr_o(e_oinstr));

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   function automatic logic [31:0] mdot(input int ew, input logic [31:0] a, b, c, input bit sat);
      longint s, x, y;
      s = longint'($signed(c));
      for (int i = 0; i < 32 / ew; i++) begin
         x = longint'((a >> (i * ew)) & ((32'd1 << ew) - 1));
         y = longint'((b >> (i * ew)) & ((32'd1 << ew) - 1));
         if (x >= (longint'(1) << (ew - 1))) x -= longint'(1) << ew;
         if (y >= (longint'(1) << (ew - 1))) y -= longint'(1) << ew;
         s += x * y;
      end
      if (sat) s = (s > SMAX) ? SMAX : (s < SMIN) ? SMIN : s;
      return s[31:0];
   endfunction

   typedef struct {logic [31:0] res; logic [3:0] id; logic [4:0] rd; logic [2:0] instr;} exp_t;
   typedef struct {logic [2:0] ins; logic [31:0] a, b, c; bit out; logic [31:0] res;} vec_t;
   exp_t sb[$];
   vec_t v[$];
   vec_t v8[$];

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_out: got result %h id %h, expected no output", out_result, out_id);
         end else begin
            e = sb.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_id", 32'(out_id), 32'(e.id));
            chk("out_rd", 32'(out_rd), 32'(e.rd));
            chk("out_instr", 32'(out_instr), 32'(e.instr));
         end
      end
   end

   // Called and returning at posedge+1; holds in_valid until the DUT accepts.
   task automatic issue(input logic [2:0] ins, input logic [3:0] id, input logic [4:0] rd,
                        input logic [31:0] a, b, c, input logic [11:0] off, input bit push,
                        input logic [31:0] exp_res);
      in_valid = 1; in_instr = ins; in_id = id; in_rd = rd; op_a = a; op_b = b; op_c = c; offset = off;
      for (int t = 0; t <= 50; t++) begin
         @(negedge clk);
         if (in_ready) break;
         if (t == 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready 0 for 50 cycles, required 1");
         end
         @(posedge clk); #1;
      end
      if (push) sb.push_back(exp_t'{exp_res, id, rd, ins});
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal;
   end

   initial begin
      logic [31:0] ra, rb, rc;
      logic [2:0] ri;
      v.push_back(vec_t'{3'd3, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 1'b1, 32'd12});
      v.push_back(vec_t'{3'd4, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_0000, 1'b1, 32'h7FFF_FFFF});
      v.push_back(vec_t'{3'd3, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_0000, 1'b1, 32'hFFFD_0002});
      v.push_back(vec_t'{3'd4, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 1'b1, 32'h8000_0000});
      v.push_back(vec_t'{3'd3, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 1'b1, 32'h0001_0000});
      v.push_back(vec_t'{3'd5, 32'h1, 32'h1, 32'h1, 1'b0, 32'h0});
      v.push_back(vec_t'{3'd0, 32'h1, 32'h1, 32'h1, 1'b0, 32'h0});
      for (int i = 0; i < 12; i++) begin
         ri = 3'($urandom_range(3, 4)); ra = $urandom; rb = $urandom; rc = $urandom;
         v.push_back(vec_t'{ri, ra, rb, rc, 1'b1, mdot(16, ra, rb, rc, ri == 3'd4)});
      end
      v8.push_back(vec_t'{3'd3, 32'hFF02_0304, 32'h0101_0101, 32'd0, 1'b1, 32'd8});
      v8.push_back(vec_t'{3'd4, 32'h8080_8080, 32'h8080_8080, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF});
      v8.push_back(vec_t'{3'd3, 32'h8080_8080, 32'h8080_8080, 32'h7FFF_FFFF, 1'b1, 32'h8000_FFFF});
      for (int i = 0; i < 6; i++) begin
         ri = 3'($urandom_range(3, 4)); ra = $urandom; rb = $urandom; rc = $urandom;
         v8.push_back(vec_t'{ri, ra, rb, rc, 1'b1, mdot(8, ra, rb, rc, ri == 3'd4)});
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      foreach (v[i]) begin
         issue(v[i].ins, 4'(i), 5'(i + 1), v[i].a, v[i].b, v[i].c, 12'd0, v[i].out, v[i].res);
         @(negedge clk);
         chk("lat1_out_valid", 32'(out_valid), 32'(v[i].out));
         @(posedge clk); #1;
      end

      issue(3'd2, 4'd3, 5'd7, 32'h1000, 32'hCAFE_BABE, 32'd0, 12'hFFC, 1'b1, 32'h0000_0FFC);
      repeat (2) begin
         @(negedge clk);
         chk("sw_wait_commit", 32'(mem_valid), 0);
         @(posedge clk); #1;
      end
      commit_valid = 1; commit_id = 4'd3; commit_kill = 0;
      @(negedge clk);
      chk("sw_commit_valid", 32'(mem_valid), 1);
      chk("sw_addr", mem_addr, 32'h1000);
      chk("sw_we", 32'(mem_we), 1);
      chk("sw_wdata", mem_wdata, 32'hCAFE_BABE);
      chk("sw_id", 32'(mem_id), 3);
      @(posedge clk); #1;
      commit_valid = 0;
      @(negedge clk);
      chk("sw_valid_held", 32'(mem_valid), 1);
      @(posedge clk); #1;
      mem_ready = 1;
      @(negedge clk);
      chk("sw_addr_stable", mem_addr, 32'h1000);
      @(posedge clk); #1;
      mem_ready = 0;
      @(negedge clk);
      chk("sw_mem_dropped", 32'(mem_valid), 0);
      chk("sw_done", 32'(out_valid), 1);
      @(posedge clk); #1;

      issue(3'd1, 4'd6, 5'd9, 32'h2000, 32'd0, 32'd0, 12'h010, 1'b1, 32'h2010);
      @(negedge clk);
      chk("lw_valid", 32'(mem_valid), 1);
      chk("lw_we", 32'(mem_we), 0);
      @(posedge clk); #1;
      mem_ready = 1;
      @(posedge clk); #1;
      mem_ready = 0;
      @(negedge clk);
      chk("lw_done", 32'(out_valid), 1);
      @(posedge clk); #1;

      issue(3'd1, 4'd5, 5'd2, 32'h2000, 32'd0, 32'd0, 12'h008, 1'b0, 32'd0);
      @(negedge clk);
      chk("lwk_valid", 32'(mem_valid), 1);
      chk("lwk_addr", mem_addr, 32'h2000);
      @(posedge clk); #1;
      commit_valid = 1; commit_id = 4'd5; commit_kill = 1;
      @(posedge clk); #1;
      commit_valid = 0; commit_kill = 0;
      @(negedge clk);
      chk("lwk_mem_drop", 32'(mem_valid), 0);
      chk("lwk_no_out", 32'(out_valid), 0);
      chk("lwk_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      issue(3'd3, 4'd9, 5'd1, 32'h0002_0003, 32'h0004_0005, 32'd1, 12'd0, 1'b1, 32'd24);
      @(negedge clk);
      chk("after_kill_out", 32'(out_valid), 1);
      @(posedge clk); #1;

      out_ready = 0;
      issue(3'd3, 4'd7, 5'd3, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 12'd0, 1'b1, 32'd12);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_result", out_result, 32'd12);
         chk("stall_ready", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      out_ready = 1;
      issue(3'd3, 4'd8, 5'd4, 32'h0001_0001, 32'h0001_0001, 32'd0, 12'd0, 1'b1, 32'd2);
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 1);
      @(posedge clk); #1;

      issue(3'd1, 4'd2, 5'd5, 32'h3000, 32'd0, 32'd0, 12'd4, 1'b0, 32'd0);
      @(negedge clk);
      chk("clr_pre_valid", 32'(mem_valid), 1);
      @(posedge clk); #1;
      clear = 1;
      @(posedge clk); #1;
      clear = 0;
      @(negedge clk);
      chk("clr_mem_valid", 32'(mem_valid), 0);
      chk("clr_in_ready", 32'(in_ready), 1);
      chk("clr_addr", mem_addr, 0);
      chk("clr_result", out_result, 0);
      @(posedge clk); #1;

      foreach (v8[i]) begin
         e_valid = 1; e_instr = v8[i].ins; e_a = v8[i].a; e_b = v8[i].b; e_c = v8[i].c; e_id = 4'd1;
         @(negedge clk);
         chk("e8_ready", 32'(e_ready), 1);
         @(posedge clk); #1;
         e_valid = 0;
         @(negedge clk);
         chk("e8_mul_stage", 32'(e_ovalid), 0);
         @(negedge clk);
         chk("e8_valid", 32'(e_ovalid), 1);
         chk("e8_result", e_res, v8[i].res);
         @(posedge clk); #1;
      end
      e_valid = 1; e_instr = 3'd3; e_id = 4'd2;
      @(posedge clk); #1;
      e_valid = 0; e_cv = 1; e_cid = 4'd2; e_ck = 1;
      @(posedge clk); #1;
      e_cv = 0; e_ck = 0;
      @(negedge clk);
      chk("e8_kill_mul_out", 32'(e_ovalid), 0);
      chk("e8_kill_mul_ready", 32'(e_ready), 1);
      @(negedge clk);
      chk("e8_kill_stays", 32'(e_ovalid), 0);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
